// File: rtl/dbg_msg_if.sv
// Byte-wide valid/ready transmit channel between the debug streamer and the UART TX path.
interface dbg_msg_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dbg_msg_streamer.sv
// Debug message generator: emits "DBG: ", a raw or ASCII-hex counting payload and CR LF
// over a valid/ready byte channel, started by a debounced button or a software trigger.
module dbg_msg_streamer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned N_VALUES        = 16,
    parameter int unsigned HEX_MODE        = 0,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       btn_in,
    input  logic       sw_trig,
    input  logic       enable,
    dbg_msg_if.master  tx,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic [7:0] byte_cnt
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned VAL_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_e;
    typedef enum logic [1:0] {SEG_HDR, SEG_PAY, SEG_TRL} seg_e;

    state_e             state_q, state_d;
    seg_e               seg_q, seg_d;
    logic [2:0]         pos_q, pos_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [1:0]         sub_q, sub_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               db_lvl_q, db_lvl_d;
    logic               btn_trig_q, btn_trig_d;

    logic               trig;
    logic               xfer;
    logic               last_byte;
    logic               timeout_hit;
    logic               gap_end;
    logic               advance;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte at a given message position; header and trailer use pos, payload uses val/sub.
    function automatic logic [7:0] msg_byte(input seg_e seg, input logic [2:0] pos,
                                            input logic [VAL_W-1:0] val, input logic [1:0] sub);
        logic [7:0] b;
        b = 8'h00;
        case (seg)
            SEG_HDR: begin
                case (pos)
                    3'd0:    b = 8'h44;
                    3'd1:    b = 8'h42;
                    3'd2:    b = 8'h47;
                    3'd3:    b = 8'h3A;
                    default: b = 8'h20;
                endcase
            end
            SEG_PAY: begin
                if (HEX_MODE == 0) begin
                    b = val;
                end else begin
                    case (sub)
                        2'd0:    b = hex_char(val[7:4]);
                        2'd1:    b = hex_char(val[3:0]);
                        default: b = 8'h20;
                    endcase
                end
            end
            default: b = (pos == 3'd0) ? 8'h0D : 8'h0A;
        endcase
        return b;
    endfunction

    // Button synchroniser and debounce: level flips after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_lvl_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        btn_trig_d = db_lvl_d & ~db_lvl_q;
    end

    assign trig        = (btn_trig_q | sw_trig) & enable & (state_q == S_IDLE);
    assign xfer        = (state_q == S_SEND) & tx_valid_q & tx.tx_ready;
    assign last_byte   = (seg_q == SEG_TRL) & (pos_q == 3'd1);
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign gap_end     = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES != 0) begin
                        state_d = S_GAP;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Position/counter updates and registered outputs, all derived from the next state.
    always_comb begin
        seg_d      = seg_q;
        pos_d      = pos_q;
        val_d      = val_q;
        sub_d      = sub_q;
        gap_cnt_d  = gap_cnt_q;
        to_cnt_d   = to_cnt_q;
        byte_cnt_d = byte_cnt_q;
        abort_d    = 1'b0;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    seg_d      = SEG_HDR;
                    pos_d      = 3'd0;
                    val_d      = '0;
                    sub_d      = 2'd0;
                    to_cnt_d   = '0;
                    byte_cnt_d = 8'd0;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                    to_cnt_d   = '0;
                    gap_cnt_d  = '0;
                    advance    = !last_byte && (GAP_CYCLES == 0);
                end else if (timeout_hit) begin
                    abort_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    advance  = 1'b1;
                    to_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: ;
        endcase

        if (advance) begin
            case (seg_q)
                SEG_HDR: begin
                    if (pos_q == 3'd4) begin
                        seg_d = SEG_PAY;
                        val_d = '0;
                        sub_d = 2'd0;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
                SEG_PAY: begin
                    if ((HEX_MODE != 0) && (sub_q != 2'd2)) begin
                        sub_d = sub_q + 2'd1;
                    end else if (val_q == VAL_W'(N_VALUES - 1)) begin
                        seg_d = SEG_TRL;
                        pos_d = 3'd0;
                    end else begin
                        val_d = val_q + VAL_W'(1);
                        sub_d = 2'd0;
                    end
                end
                default: pos_d = pos_q + 3'd1;
            endcase
        end

        tx_valid_d = (state_d == S_SEND);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        tx_data_d  = (state_d == S_SEND) ? msg_byte(seg_d, pos_d, val_d, sub_d) : tx_data_q;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            db_lvl_q   <= 1'b0;
            btn_trig_q <= 1'b0;
            seg_q      <= SEG_HDR;
            pos_q      <= 3'd0;
            val_q      <= '0;
            sub_q      <= 2'd0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            byte_cnt_q <= 8'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            btn_trig_q <= btn_trig_d;
            seg_q      <= seg_d;
            pos_q      <= pos_d;
            val_q      <= val_d;
            sub_q      <= sub_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign byte_cnt    = byte_cnt_q;

endmodule
